// File: rtl/dmem_uart_tx_pkg.sv
// Shared constants, status bit map and serializer state encoding for dmem_uart_tx.
// The parity slot is only used when DMEM_UART_TX_PARITY_EN is defined.
package dmem_uart_tx_pkg;

    localparam int WORD_LEN = 32;

    localparam logic [2:0] UART_TXDATA_OFS = 3'h0;
    localparam logic [2:0] UART_STATUS_OFS = 3'h4;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_BUSY_BIT  = 2;
    localparam int STATUS_OVF_BIT   = 3;
    localparam int STATUS_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter with first-word-fall-through output.
// A push while full is still taken when a pop happens on the same edge.
module uart_tx_fifo
    import dmem_uart_tx_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_en_s;
    logic             rd_en_s;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign rd_en_s = pop_i && !empty_o;
    assign wr_en_s = push_i && (!full_o || rd_en_s);

    // Storage array; contents are don't-care until counted in, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dmem_uart_tx.sv
// Memory-mapped UART transmitter on the DmemPort: TXDATA at +0x0, STATUS at +0x4.
// Define DMEM_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module dmem_uart_tx
    import dmem_uart_tx_pkg::*;
#(
    parameter logic [WORD_LEN-1:0] BASE_ADDR    = 32'h0000_8000,
    parameter int                  CLKS_PER_BIT = 16,
    parameter int                  FIFO_DEPTH   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WORD_LEN-1:0] addr_d,
    input  logic [WORD_LEN-1:0] wdata,
    input  logic                wen,
    output logic [WORD_LEN-1:0] rdata,
    output logic                tx
);

    localparam int            TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    tx_state_e       state_q;
    logic [TW-1:0]   timer_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic            tx_q;
    logic            ovf_q;
    logic            ovf_d;

    logic            sel_s;
    logic            txdata_sel_s;
    logic            status_sel_s;
    logic            push_s;
    logic            pop_s;
    logic            drop_s;
    logic            clr_s;
    logic            full_s;
    logic            empty_s;
    logic            busy_s;
    logic [CW-1:0]   count_s;
    logic [7:0]      fifo_dout_s;
    logic [WORD_LEN-1:0] status_s;
    logic            unused_wdata_s;

    assign sel_s        = (addr_d[WORD_LEN-1:3] == BASE_ADDR[WORD_LEN-1:3]);
    assign txdata_sel_s = sel_s && (addr_d[2:0] == UART_TXDATA_OFS);
    assign status_sel_s = sel_s && (addr_d[2:0] == UART_STATUS_OFS);
    assign push_s       = wen && txdata_sel_s;
    assign pop_s        = (state_q == ST_IDLE) && !empty_s;
    assign drop_s       = push_s && full_s && !pop_s;
    assign clr_s        = wen && status_sel_s && wdata[STATUS_OVF_BIT];
    assign busy_s       = (state_q != ST_IDLE);
    assign tx           = tx_q;
    assign unused_wdata_s = ^wdata[WORD_LEN-1:8];

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   (wdata[7:0]),
        .dout_o  (fifo_dout_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    // Sticky overflow: a dropped push wins; a STATUS write with bit 3 clears it.
    always_comb begin
        ovf_d = ovf_q;
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Read mux: only STATUS returns data, everything else in or out of range reads zero.
    always_comb begin
        status_s                                = '0;
        status_s[STATUS_FULL_BIT]               = full_s;
        status_s[STATUS_EMPTY_BIT]              = empty_s;
        status_s[STATUS_BUSY_BIT]               = busy_s;
        status_s[STATUS_OVF_BIT]                = ovf_q;
        status_s[STATUS_COUNT_LSB +: CW]        = count_s;
        if (status_sel_s) begin
            rdata = status_s;
        end else begin
            rdata = '0;
        end
    end

    // Serializer: tx is loaded with the level of the state being entered, so it never glitches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            case (state_q)
                ST_IDLE: begin
                    if (!empty_s) begin
                        shift_q <= fifo_dout_s;
                        state_q <= ST_START;
                        timer_q <= BIT_LAST;
                        tx_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (timer_q == '0) begin
                        state_q <= ST_DATA;
                        timer_q <= BIT_LAST;
                        idx_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                ST_DATA: begin
                    if (timer_q == '0) begin
                        timer_q <= BIT_LAST;
                        if (idx_q == 3'd7) begin
                            idx_q <= 3'd0;
`ifdef DMEM_UART_TX_PARITY_EN
                            state_q <= ST_PARITY;
                            tx_q    <= even_parity(shift_q);
`else
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            tx_q  <= shift_q[idx_q + 3'd1];
                        end
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                ST_PARITY: begin
                    if (timer_q == '0) begin
                        state_q <= ST_STOP;
                        timer_q <= BIT_LAST;
                        tx_q    <= 1'b1;
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                ST_STOP: begin
                    if (timer_q == '0) begin
                        state_q <= ST_IDLE;
                        tx_q    <= 1'b1;
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    timer_q <= '0;
                    idx_q   <= 3'd0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_uart_tx.sv
// Self-checking bench for dmem_uart_tx: register-map vector table plus frame, FIFO and reset sequences.
// Frame model follows DMEM_UART_TX_PARITY_EN the same way the design does.
module tb_dmem_uart_tx;

    localparam logic [31:0] BASE  = 32'h0000_8000;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_ST  = BASE + 32'h0000_0004;
    localparam int          CPB   = 16;
`ifdef DMEM_UART_TX_PARITY_EN
    localparam int          SLOTS = 11;
`else
    localparam int          SLOTS = 10;
`endif
    localparam int          FRAME = CPB * SLOTS;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr_d = A_ST;
    logic [31:0] wdata  = 32'd0;
    logic        wen    = 1'b0;
    logic [31:0] rdata;
    logic        tx;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd_addr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [9];

    dmem_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr_d (addr_d),
        .wdata  (wdata),
        .wen    (wen),
        .rdata  (rdata),
        .tx     (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic rd_status(input string name, input logic [31:0] exp);
        addr_d = A_ST;
        wen    = 1'b0;
        #1;
        chk(name, rdata, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_d = a;
        wdata  = d;
        wen    = 1'b1;
        step();
        wen    = 1'b0;
        addr_d = A_ST;
    endtask

    function automatic logic exp_tx_bit(input logic [7:0] b, input int slot);
        logic r;
        if (slot == 0) r = 1'b0;
        else if (slot <= 8) r = b[slot-1];
`ifdef DMEM_UART_TX_PARITY_EN
        else if (slot == 9) r = ^b;
`endif
        else r = 1'b1;
        return r;
    endfunction

    // Queue one or two bytes from idle and compare tx/busy every cycle against the frame model.
    task automatic send_frames(input string name, input logic [31:0] d0, input logic [7:0] d1, input int nb);
        int         bad_tx;
        int         bad_busy;
        int         total;
        int         f;
        int         r;
        logic [7:0] b;
        logic       et;
        logic       eb;
        bad_tx   = 0;
        bad_busy = 0;
        wr(A_TX, d0);
        chk({name, "_pre_tx"}, {31'd0, tx}, 32'd1);
        rd_status({name, "_queued"}, 32'h0000_0100);
        if (nb == 2) wr(A_TX, {24'd0, d1});
        else step();
        total = nb * FRAME + nb - 1;
        for (int i = 0; i < total; i++) begin
            #1;
            f  = i / (FRAME + 1);
            r  = i % (FRAME + 1);
            b  = (f == 0) ? d0[7:0] : d1;
            if (r == FRAME) begin
                et = 1'b1;
                eb = 1'b0;
            end else begin
                et = exp_tx_bit(b, r / CPB);
                eb = 1'b1;
            end
            if (tx !== et) bad_tx++;
            if (rdata[2] !== eb) bad_busy++;
            step();
        end
        chk({name, "_wave_bad_cycles"}, bad_tx, 32'd0);
        chk({name, "_busy_bad_cycles"}, bad_busy, 32'd0);
        chk({name, "_end_tx"}, {31'd0, tx}, 32'd1);
        rd_status({name, "_end_status"}, 32'h0000_0002);
    endtask

    initial begin
        int   found;
        int   bad;

        // Reset held: tx idle high throughout.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_tx", {31'd0, tx}, 32'd1);
        end
        rst_n = 1'b1;
        rd_status("rst_status", 32'h0000_0002);
        step();
        chk("post_rst_tx", {31'd0, tx}, 32'd1);

        vecs[0] = '{1'b0, A_ST,               32'h0000_0000, A_ST,               32'h0000_0002, "idle_status"};
        vecs[1] = '{1'b0, A_ST,               32'h0000_0000, A_TX,               32'h0000_0000, "txdata_rd_zero"};
        vecs[2] = '{1'b0, A_ST,               32'h0000_0000, BASE + 32'h8,       32'h0000_0000, "ofs8_rd_zero"};
        vecs[3] = '{1'b1, BASE + 32'h8,       32'h0000_0041, A_ST,               32'h0000_0002, "ofs8_wr_ignored"};
        vecs[4] = '{1'b1, BASE + 32'hC,       32'h0000_0042, A_ST,               32'h0000_0002, "ofsC_wr_ignored"};
        vecs[5] = '{1'b1, 32'h0000_9000,      32'h0000_0043, A_ST,               32'h0000_0002, "other_base_wr"};
        vecs[6] = '{1'b0, A_ST,               32'h0000_0000, 32'h0000_9004,      32'h0000_0000, "other_base_rd"};
        vecs[7] = '{1'b1, A_ST,               32'hFFFF_FFFF, A_ST,               32'h0000_0002, "status_wr_noop"};
        vecs[8] = '{1'b1, BASE + 32'h10,      32'h0000_0044, BASE + 32'h10,      32'h0000_0000, "next_block_wr"};

        for (int i = 0; i < 9; i++) begin
            addr_d = vecs[i].addr;
            wdata  = vecs[i].wdata;
            wen    = vecs[i].wen;
            step();
            wen    = 1'b0;
            addr_d = vecs[i].rd_addr;
            #1;
            chk(vecs[i].name, rdata, vecs[i].exp);
            chk({vecs[i].name, "_tx"}, {31'd0, tx}, 32'd1);
        end
        rd_status("table_end_status", 32'h0000_0002);

        // Frames: 0x55 (upper wdata ignored), two contiguous bytes, parity sample 0x07.
        send_frames("f55", 32'h0000_0155, 8'h00, 1);
        send_frames("f4142", 32'h0000_0041, 8'h42, 2);
        send_frames("f07", 32'h0000_0007, 8'h00, 1);

        // Nine writes from idle: first pops at once, FIFO ends full with no overflow.
        for (int k = 0; k < 9; k++) wr(A_TX, 32'h0000_0030 + k);
        rd_status("fill9", 32'h0000_0805);
        wr(A_TX, 32'h0000_0039);
        rd_status("drop10_ovf", 32'h0000_080D);
        wr(A_ST, 32'h0000_0007);
        rd_status("ovf_kept", 32'h0000_080D);
        wr(A_ST, 32'h0000_0008);
        rd_status("ovf_cleared", 32'h0000_0805);

        // Wait for the idle cycle, then push while full as that cycle pops.
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            #1;
            if (rdata[2] == 1'b0) found = 1;
            else step();
        end
        chk("idle_wait_found", found, 32'd1);
        chk("idle_full_status", rdata, 32'h0000_0801);
        wr(A_TX, 32'h0000_00AA);
        rd_status("full_push_pop", 32'h0000_0805);

        // Reset partway through the data bits with the FIFO loaded.
        for (int i = 0; i < 25; i++) step();
        chk("pre_rst_busy", {31'd0, rdata[2]}, 32'd1);
        rst_n = 1'b0;
        step();
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        rd_status("midrst_status", 32'h0000_0002);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            #1;
            if (tx !== 1'b1 || rdata !== 32'h0000_0002) bad++;
        end
        chk("post_rst_quiet_bad_cycles", bad, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
